// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives the PLL reset and qualifies the asynchronous
// locked indication. The system reset is released only after lock has been
// stable for long enough. The supervisor retries when lock times out and
// re-sequences the PLL when lock is lost in RUN.
// Optional build macro PLL_SUPV_LOSS_FILTER_EN: when it is defined, lock loss
// in RUN is declared only after locked_s has been low for 4 consecutive cycles.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned CNT_W            = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             fail,
  output logic [CNT_W-1:0] relock_cnt,
  output logic [2:0]       state
);

  localparam int unsigned TMR_MAX  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC
                                                                        : LOCK_TIMEOUT_CYC;
  localparam int unsigned TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned STB_W    = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
  localparam int unsigned RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    ST_PLLRST    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [STB_W-1:0]   stable_q, stable_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]   relock_q, relock_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               sync1_q, sync1_d;
  logic               locked_s_q, locked_s_d;
  logic               loss_c;

  // Two-flop synchronizer inputs for the asynchronous locked indication
  always_comb begin
    sync1_d    = pll_locked;
    locked_s_d = sync1_q;
  end

`ifdef PLL_SUPV_LOSS_FILTER_EN
  logic [1:0] filt_q, filt_d;

  // Lock loss in RUN only after four consecutive low samples of locked_s
  always_comb begin
    filt_d = '0;
    loss_c = 1'b0;
    if (state_q == ST_RUN && !locked_s_q) begin
      if (filt_q == 2'd3) begin
        loss_c = 1'b1;
      end else begin
        filt_d = filt_q + 2'd1;
      end
    end
  end

  // Dropout filter counter
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  // Any single low sample of locked_s in RUN is a lock-loss event
  always_comb begin
    loss_c = (state_q == ST_RUN) && !locked_s_q;
  end
`endif

  // Next-state, counters and registered-output decode
  always_comb begin
    logic [RETRY_W-1:0] retry_inc;
    state_d   = state_q;
    timer_d   = timer_q;
    stable_d  = stable_q;
    retry_d   = retry_q;
    relock_d  = relock_q;
    retry_inc = retry_q + RETRY_W'(1);

    case (state_q)
      ST_PLLRST: begin
        if (timer_q == TMR_W'(RST_PULSE_CYC - 1)) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d  = ST_STABLE;
          timer_d  = '0;
          stable_d = '0;
        end else if (timer_q == TMR_W'(LOCK_TIMEOUT_CYC - 1)) begin
          retry_d = retry_inc;
          timer_d = '0;
          state_d = (retry_inc == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_PLLRST;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_STABLE: begin
        if (!locked_s_q) begin
          state_d  = ST_WAIT_LOCK;
          timer_d  = '0;
          stable_d = '0;
        end else if (stable_q == STB_W'(LOCK_STABLE_CYC - 1)) begin
          state_d  = ST_RUN;
          stable_d = '0;
          retry_d  = '0;
        end else begin
          stable_d = stable_q + STB_W'(1);
        end
      end
      ST_RUN: begin
        if (loss_c) begin
          state_d = ST_PLLRST;
          timer_d = '0;
          if (relock_q != {CNT_W{1'b1}}) begin
            relock_d = relock_q + CNT_W'(1);
          end
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d  = ST_PLLRST;
        timer_d  = '0;
        stable_d = '0;
      end
    endcase

    pll_rst_d = (state_d == ST_PLLRST);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  // State, counters, synchronizer and output registers
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PLLRST;
      timer_q    <= '0;
      stable_q   <= '0;
      retry_q    <= '0;
      relock_q   <= '0;
      pll_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      stable_q   <= stable_d;
      retry_q    <= retry_d;
      relock_q   <= relock_d;
      pll_rst_q  <= pll_rst_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
      sync1_q    <= sync1_d;
      locked_s_q <= locked_s_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst    = sys_rst_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign relock_cnt = relock_q;
  assign state      = state_q;

endmodule
